demux16_capture: RTL and testbench

DEMUX16_CAPTURE -- requirements
Module: demux16_capture

---
 rtl/demux16_capture_pkg.sv | 13 +
 rtl/demux16_decode.sv | 19 +
 rtl/demux16_capture.sv | 88 ++++++++
 tb/tb_demux16_capture.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux16_capture_pkg.sv
// Shared types and constants for the 16-slot demux capture block.
package demux16_capture_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int SLOTS = 16;
    localparam int SEL_W = 4;
    localparam logic [SLOTS-1:0] FULL_MASK = 16'hFFFF;

endpackage

// File: rtl/demux16_decode.sv
// 4-to-16 one-hot decode of the slot address, gated by the active-low strobe.
// This is the inverse of the 16:1 selector feeding din.
module demux16_decode
    import demux16_capture_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en_n,
    output logic [SLOTS-1:0] onehot
);

    // One bit per slot, all zero when no strobe is present.
    always_comb begin
        onehot = '0;
        if (!en_n) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux16_capture.sv
// Captures serial bits from a 16:1 mux output into a 16-bit word, slot by
// slot, and presents the word with a valid/ready handshake once every slot
// has been written or a flush is requested.
module demux16_capture
    import demux16_capture_pkg::*;
#(
    parameter bit INVERT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    input  logic             en_n,
    input  logic             flush,
    output logic             in_ready,
    output logic [SLOTS-1:0] out_data,
    output logic [SLOTS-1:0] out_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dup_err
);

    state_t           state;
    logic [SLOTS-1:0] shadow;
    logic [SLOTS-1:0] mask;
    logic [SLOTS-1:0] strobe;
    logic [SLOTS-1:0] wr;
    logic [SLOTS-1:0] next_mask;
    logic             cap_bit;
    logic             dup_hit;
    logic             go_present;

    demux16_decode u_decode (
        .sel    (sel),
        .en_n   (en_n),
        .onehot (strobe)
    );

    // The mux drives its output inverted, so undo that when INVERT is set.
    assign cap_bit    = INVERT ? ~din : din;
    // Strobes only land while collecting; in PRESENT they are dropped.
    assign wr         = (state == COLLECT) ? strobe : '0;
    assign next_mask  = mask | wr;
    assign dup_hit    = |(wr & mask);
    // The mask after this edge decides the transition, so a strobe arriving
    // with flush (or the 16th strobe) is part of the presented word.
    assign go_present = (next_mask == FULL_MASK) || (flush && (next_mask != '0));

    assign out_mask = mask;
    assign out_data = shadow & mask;

    // Collect/present state machine with its registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            shadow    <= '0;
            mask      <= '0;
            dup_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    shadow <= (shadow & ~wr) | (wr & {SLOTS{cap_bit}});
                    mask   <= next_mask;
                    if (dup_hit) begin
                        dup_err <= 1'b1;
                    end
                    if (go_present) begin
                        state     <= PRESENT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        shadow    <= '0;
                        mask      <= '0;
                        state     <= COLLECT;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux16_capture.sv
// Self-checking bench for demux16_capture: two instances (INVERT=1 and
// INVERT=0) share the same stimulus and are compared against a slot-level
// behavioural model.
module tb_demux16_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [3:0]  sel;
    logic        en_n;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1, dup_err1;
    logic [15:0] out_data1, out_mask1;
    logic        in_ready0, out_valid0, dup_err0;
    logic [15:0] out_data0, out_mask0;

    int checks   = 0;
    int failures = 0;

    // Model: per-slot written flag and raw din value, word-present flag,
    // sticky duplicate flag.
    bit m_written[16];
    bit m_val[16];
    bit m_present;
    bit m_dup;

    always #5 clk = ~clk;

    demux16_capture #(.INVERT(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .en_n      (en_n),
        .flush     (flush),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_mask  (out_mask1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .dup_err   (dup_err1)
    );

    demux16_capture #(.INVERT(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .en_n      (en_n),
        .flush     (flush),
        .in_ready  (in_ready0),
        .out_data  (out_data0),
        .out_mask  (out_mask0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .dup_err   (dup_err0)
    );

    function automatic logic [15:0] m_mask();
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[i] = m_written[i];
        return r;
    endfunction

    function automatic logic [15:0] m_raw();
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[i] = m_val[i];
        return r;
    endfunction

    function automatic logic [69:0] expv();
        logic [15:0] mk = m_mask();
        logic [15:0] rw = m_raw();
        return {!m_present, m_present, m_dup, mk, ~rw & mk,
                !m_present, m_present, m_dup, mk,  rw & mk};
    endfunction

    function automatic logic [69:0] obs();
        return {in_ready1, out_valid1, dup_err1, out_mask1, out_data1,
                in_ready0, out_valid0, dup_err0, out_mask0, out_data0};
    endfunction

    task automatic model_edge();
        bit all_set;
        bit any_set;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_written[i] = 1'b0;
                m_val[i]     = 1'b0;
            end
            m_present = 1'b0;
            m_dup     = 1'b0;
        end else if (!m_present) begin
            if (!en_n) begin
                if (m_written[sel]) m_dup = 1'b1;
                m_written[sel] = 1'b1;
                m_val[sel]     = din;
            end
            all_set = 1'b1;
            any_set = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (!m_written[i]) all_set = 1'b0;
                if (m_written[i])  any_set = 1'b1;
            end
            if (all_set || (flush && any_set)) m_present = 1'b1;
        end else if (out_ready) begin
            for (int i = 0; i < 16; i++) begin
                m_written[i] = 1'b0;
                m_val[i]     = 1'b0;
            end
            m_present = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst_n     = 1'b1;
        en_n      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        din       = 1'b0;
        sel       = 4'd0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        en_n  = 1'b0;
        flush = 1'b1;
        din   = 1'b1;
        sel   = 4'd6;
        step();
        idle();
        checks++;
        if ({in_ready1, out_valid1, out_data1, out_mask1, dup_err1} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h",
                     {in_ready1, out_valid1, out_data1, out_mask1, dup_err1}, {1'b1, 1'b0, 16'h0, 16'h0, 1'b0});
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_model got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_full_word();
        logic [15:0] pat = 16'hA5C3;
        for (int k = 0; k < 16; k++) begin
            sel  = 4'(k);
            din  = ~pat[k];
            en_n = 1'b0;
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL full_word_step%0d got=%h want=%h", k, obs(), expv());
            end
            if (k == 14) begin
                checks++;
                if (out_valid1 !== 1'b0) begin
                    failures++;
                    $display("FAIL full_word_early_valid got=%b want=0", out_valid1);
                end
            end
        end
        idle();
        checks++;
        if ({out_valid1, out_data1, out_mask1, out_data0} !== {1'b1, 16'hA5C3, 16'hFFFF, 16'h5A3C}) begin
            failures++;
            $display("FAIL full_word got=%h want=%h",
                     {out_valid1, out_data1, out_mask1, out_data0}, {1'b1, 16'hA5C3, 16'hFFFF, 16'h5A3C});
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            en_n      = 1'b0;
            sel       = 4'($urandom_range(15, 0));
            din       = 1'($urandom_range(1, 0));
            flush     = 1'($urandom_range(1, 0));
            out_ready = 1'b0;
            step();
            checks++;
            if ({out_data1, in_ready1, out_valid1, dup_err1} !== {16'hA5C3, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL backpressure_hold%0d got=%h want=%h", c,
                         {out_data1, in_ready1, out_valid1, dup_err1}, {16'hA5C3, 1'b0, 1'b1, 1'b0});
            end
        end
        // A strobe on the handshake edge itself must not be captured.
        en_n      = 1'b0;
        sel       = 4'd2;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        idle();
        checks++;
        if ({out_valid1, in_ready1, out_mask1, out_data1} !== {1'b0, 1'b1, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL backpressure_release got=%h want=%h",
                     {out_valid1, in_ready1, out_mask1, out_data1}, {1'b0, 1'b1, 16'h0, 16'h0});
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL backpressure_model got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_flush_strobe();
        en_n = 1'b0;
        din  = 1'b0;
        sel  = 4'd3;
        step();
        sel  = 4'd9;
        step();
        checks++;
        if (out_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL flush_premature got=%b want=0", out_valid1);
        end
        sel   = 4'd12;
        flush = 1'b1;
        step();
        idle();
        checks++;
        if ({out_valid1, out_mask1, out_data1, out_mask0, out_data0} !== {1'b1, 16'h1208, 16'h1208, 16'h1208, 16'h0000}) begin
            failures++;
            $display("FAIL flush_strobe got=%h want=%h",
                     {out_valid1, out_mask1, out_data1, out_mask0, out_data0},
                     {1'b1, 16'h1208, 16'h1208, 16'h1208, 16'h0000});
        end
        out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_dup();
        checks++;
        if (dup_err1 !== 1'b0) begin
            failures++;
            $display("FAIL dup_before got=%b want=0", dup_err1);
        end
        en_n = 1'b0;
        sel  = 4'd5;
        din  = 1'b0;
        step();
        din  = 1'b1;
        step();
        idle();
        checks++;
        if ({dup_err1, dup_err0} !== 2'b11) begin
            failures++;
            $display("FAIL dup_flag got=%b want=11", {dup_err1, dup_err0});
        end
        flush = 1'b1;
        step();
        idle();
        checks++;
        if ({out_valid1, out_mask1, out_data1[5], out_data0[5]} !== {1'b1, 16'h0020, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL dup_overwrite got=%h want=%h",
                     {out_valid1, out_mask1, out_data1[5], out_data0[5]}, {1'b1, 16'h0020, 1'b0, 1'b1});
        end
        out_ready = 1'b1;
        step();
        idle();
        checks++;
        if ({dup_err1, out_valid1} !== 2'b10) begin
            failures++;
            $display("FAIL dup_sticky got=%b want=10", {dup_err1, out_valid1});
        end
    endtask

    task automatic test_reset_present();
        int          perm[16];
        logic [15:0] bits;
        en_n  = 1'b0;
        sel   = 4'd0;
        din   = 1'b1;
        flush = 1'b1;
        step();
        idle();
        checks++;
        if (out_valid1 !== 1'b1) begin
            failures++;
            $display("FAIL rstp_setup got=%b want=1", out_valid1);
        end
        rst_n = 1'b0;
        en_n  = 1'b0;
        sel   = 4'd7;
        flush = 1'b1;
        step();
        idle();
        checks++;
        if ({out_valid1, in_ready1, out_mask1, dup_err1} !== {1'b0, 1'b1, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL rstp_cleared got=%h want=%h",
                     {out_valid1, in_ready1, out_mask1, dup_err1}, {1'b0, 1'b1, 16'h0, 1'b0});
        end
        step();
        checks++;
        if ({out_valid1, out_mask1} !== {1'b0, 16'h0}) begin
            failures++;
            $display("FAIL rstp_no_partial got=%h want=%h", {out_valid1, out_mask1}, {1'b0, 16'h0});
        end
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        bits = 16'($urandom);
        for (int k = 0; k < 16; k++) begin
            en_n = 1'b0;
            sel  = 4'(perm[k]);
            din  = bits[perm[k]];
            step();
        end
        idle();
        checks++;
        if ({out_valid1, out_data1, out_data0, out_mask1, dup_err1} !== {1'b1, ~bits, bits, 16'hFFFF, 1'b0}) begin
            failures++;
            $display("FAIL rstp_word got=%h want=%h",
                     {out_valid1, out_data1, out_data0, out_mask1, dup_err1}, {1'b1, ~bits, bits, 16'hFFFF, 1'b0});
        end
        out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_invert0_random();
        int          perm[16];
        logic [15:0] bits;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({out_valid0, out_valid1, in_ready0} !== 3'b001) begin
            failures++;
            $display("FAIL empty_flush got=%b want=001", {out_valid0, out_valid1, in_ready0});
        end
        step();
        checks++;
        if (out_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush_later got=%b want=0", out_valid0);
        end
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        bits = 16'($urandom);
        for (int k = 0; k < 16; k++) begin
            en_n = 1'b0;
            sel  = 4'(perm[k]);
            din  = bits[perm[k]];
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL inv0_step%0d got=%h want=%h", k, obs(), expv());
            end
        end
        idle();
        checks++;
        if ({out_valid0, out_data0, out_mask0} !== {1'b1, bits, 16'hFFFF}) begin
            failures++;
            $display("FAIL inv0_word got=%h want=%h", {out_valid0, out_data0, out_mask0}, {1'b1, bits, 16'hFFFF});
        end
        out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(59, 0) != 0);
            en_n      = ($urandom_range(9, 0) < 3);
            sel       = 4'($urandom_range(15, 0));
            din       = 1'($urandom_range(1, 0));
            flush     = ($urandom_range(7, 0) == 0);
            out_ready = ($urandom_range(2, 0) == 0);
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h want=%h", c, obs(), expv());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush_strobe();
        test_dup();
        test_reset_present();
        test_invert0_random();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
